mem_cmd_initiator: RTL and testbench

MEM_CMD_INITIATOR -- requirements
Module: mem_cmd_initiator

---
 rtl/mem_cmd_initiator.sv | 203 ++++++++++++++++++++
 tb/tb_mem_cmd_initiator.sv | 359 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_cmd_initiator.sv
// -----------------------------------------------------------------------------
// mem_cmd_initiator
//
// Purpose:
//   Accepts read/write commands into a small FIFO and issues them one at a
//   time, in order, to a memory with separate write and read ports. Each read
//   produces a held response that must be consumed before the next command is
//   issued. Writes produce no response.
//
// Parameters:
//   CMD_DEPTH      command FIFO entries (power of 2, 2..16)
//
// Ports:
//   CLK            single rising-edge clock
//   RST_N          asynchronous active-low reset
//   cmd_valid      command offered
//   cmd_ready      FIFO can accept (not full, and out of reset)
//   cmd_op         1 = write, 0 = read
//   cmd_addr       target address (3 bits)
//   cmd_data       write data (ignored for reads)
//   rsp_valid      read response held
//   rsp_ready      response consumed
//   rsp_addr       address of the read being answered
//   rsp_data       read value
//   rsp_err        shadow mismatch flag (0 unless shadow check is built in)
//   write_address  memory write port address
//   write_data     memory write port data
//   write_en       memory write port enable (only while write_rdy is high)
//   write_rdy      memory write port ready
//   read_address   memory read port address
//   read_en        memory read port enable (only while read_rdy is high)
//   read_rdy       memory read port ready
//   read_data      memory read data, valid when read_en && read_rdy
//
// Build option:
//   MEM_CMD_INITIATOR_SHADOW_CHECK_EN  keeps an 8-entry 1-bit shadow of every
//   write and flags rsp_err when a read returns a value that differs from it.
// -----------------------------------------------------------------------------
module mem_cmd_initiator #(
    parameter int CMD_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_op,
    input  logic [2:0] cmd_addr,
    input  logic       cmd_data,
    output logic       rsp_valid,
    input  logic       rsp_ready,
    output logic [2:0] rsp_addr,
    output logic       rsp_data,
    output logic       rsp_err,
    output logic [2:0] write_address,
    output logic       write_data,
    output logic       write_en,
    input  logic       write_rdy,
    output logic [2:0] read_address,
    output logic       read_en,
    input  logic       read_rdy,
    input  logic       read_data
);

    localparam int PTR_W = $clog2(CMD_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {
        IDLE,
        WR,
        RD,
        RESP
    } state_t;

    state_t state;

    // Command FIFO storage and bookkeeping
    logic [CMD_DEPTH-1:0] fifo_op;
    logic [CMD_DEPTH-1:0] fifo_data;
    logic [2:0]           fifo_addr [CMD_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [CNT_W-1:0]     count;

    // Held low through reset so cmd_ready stays 0 until the first edge after
    // RST_N rises, even though the FIFO already reads as empty.
    logic                 ready_q;

    // Issued command and captured response
    logic [2:0]           cmd_addr_q;
    logic                 cmd_data_q;
    logic [2:0]           rsp_addr_q;
    logic                 rsp_data_q;

    logic fifo_full;
    logic fifo_empty;
    logic push;
    logic pop;

    assign fifo_full  = (count == CNT_W'(CMD_DEPTH));
    assign fifo_empty = (count == '0);
    assign cmd_ready  = ready_q && !fifo_full;
    assign push       = cmd_valid && cmd_ready;
    assign pop        = (state == IDLE) && !fifo_empty;

    assign write_en      = (state == WR) && write_rdy;
    assign read_en       = (state == RD) && read_rdy;
    assign write_address = cmd_addr_q;
    assign write_data    = cmd_data_q;
    assign read_address  = cmd_addr_q;
    assign rsp_valid     = (state == RESP);
    assign rsp_addr      = rsp_addr_q;
    assign rsp_data      = rsp_data_q;

    // FIFO payload; contents are meaningless while count says empty, so no reset
    always_ff @(posedge CLK) begin
        if (push) begin
            fifo_op[wr_ptr]   <= cmd_op;
            fifo_data[wr_ptr] <= cmd_data;
            fifo_addr[wr_ptr] <= cmd_addr;
        end
    end

    // Pointers wrap naturally because CMD_DEPTH is a power of 2
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef MEM_CMD_INITIATOR_SHADOW_CHECK_EN
    logic [7:0] shadow;
    logic       rsp_err_q;
    assign rsp_err = rsp_err_q;
`else
    assign rsp_err = 1'b0;
`endif

    // Issue FSM: one command in flight, from pop to write fire or response consumed
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state      <= IDLE;
            cmd_addr_q <= '0;
            cmd_data_q <= 1'b0;
            rsp_addr_q <= '0;
            rsp_data_q <= 1'b0;
`ifdef MEM_CMD_INITIATOR_SHADOW_CHECK_EN
            shadow     <= '0;
            rsp_err_q  <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (!fifo_empty) begin
                        cmd_addr_q <= fifo_addr[rd_ptr];
                        cmd_data_q <= fifo_data[rd_ptr];
                        state      <= fifo_op[rd_ptr] ? WR : RD;
                    end
                end
                WR: begin
                    if (write_rdy) begin
`ifdef MEM_CMD_INITIATOR_SHADOW_CHECK_EN
                        shadow[cmd_addr_q] <= cmd_data_q;
`endif
                        state <= IDLE;
                    end
                end
                RD: begin
                    if (read_rdy) begin
                        rsp_addr_q <= cmd_addr_q;
                        rsp_data_q <= read_data;
`ifdef MEM_CMD_INITIATOR_SHADOW_CHECK_EN
                        rsp_err_q  <= (read_data != shadow[cmd_addr_q]);
`endif
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rsp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_cmd_initiator.sv
// -----------------------------------------------------------------------------
// tb_mem_cmd_initiator
//
// Self-checking bench for mem_cmd_initiator (CMD_DEPTH = 4). A reference model
// keeps the queue of accepted commands in arrival order plus an 8-entry memory
// image; every write/read issue and every consumed response is checked against
// it. Directed steps cover latency, stalls, FIFO full, reset and push/pop
// overlap; a randomized phase follows, then a drain.
// -----------------------------------------------------------------------------
module tb_mem_cmd_initiator;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic       op;
        logic [2:0] addr;
        logic       data;
    } cmd_t;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic       cmd_op = 1'b0;
    logic [2:0] cmd_addr = 3'd0;
    logic       cmd_data = 1'b0;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [2:0] rsp_addr;
    logic       rsp_data;
    logic       rsp_err;
    logic [2:0] write_address;
    logic       write_data;
    logic       write_en;
    logic       write_rdy = 1'b0;
    logic [2:0] read_address;
    logic       read_en;
    logic       read_rdy = 1'b0;
    logic       read_data = 1'b0;

    int vectors = 0;
    int miscompares = 0;

    cmd_t       expQ[$];
    logic       rspPending = 1'b0;
    logic [2:0] pendAddr = 3'd0;
    logic       pendData = 1'b0;
    logic       pendErr = 1'b0;
    logic [7:0] memImage = 8'd0;

    mem_cmd_initiator #(.CMD_DEPTH(DEPTH)) dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_addr     (cmd_addr),
        .cmd_data     (cmd_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_addr     (rsp_addr),
        .rsp_data     (rsp_data),
        .rsp_err      (rsp_err),
        .write_address(write_address),
        .write_data   (write_data),
        .write_en     (write_en),
        .write_rdy    (write_rdy),
        .read_address (read_address),
        .read_en      (read_en),
        .read_rdy     (read_rdy),
        .read_data    (read_data)
    );

    // Free-running clock, 10 time units per cycle
    always #5 CLK = ~CLK;

    // Hard stop in case something stalls the sequence
    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // One comparison point: count it, and count/report it if it misses
    task automatic checkOutput(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drive all inputs for the current cycle, then let combinational outputs settle
    task automatic applyStimulus(input logic v, input logic op, input logic [2:0] a, input logic d,
                                 input logic wr, input logic rr, input logic rdat, input logic rspr);
        cmd_valid = v;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_data  = d;
        write_rdy = wr;
        read_rdy  = rr;
        read_data = rdat;
        rsp_ready = rspr;
        #1;
    endtask

    // Expected rsp_err for a read of address a returning value d
    function automatic logic expectedErr(input logic [2:0] a, input logic d);
`ifdef MEM_CMD_INITIATOR_SHADOW_CHECK_EN
        return d != memImage[a];
`else
        return 1'b0;
`endif
    endfunction

    // Reference model: issue order, memory image and responses
    task automatic monitorCycle();
        cmd_t c;
        checkOutput("wen_without_rdy", 8'(write_en & ~write_rdy), 8'd0);
        checkOutput("ren_without_rdy", 8'(read_en & ~read_rdy), 8'd0);
        if (write_en) begin
            checkOutput("write_has_cmd", 8'(expQ.size() != 0), 8'd1);
            checkOutput("write_while_rsp", 8'(rspPending), 8'd0);
            if (expQ.size() != 0) begin
                c = expQ.pop_front();
                checkOutput("write_op", 8'(c.op), 8'd1);
                checkOutput("write_addr", 8'(write_address), 8'(c.addr));
                checkOutput("write_data", 8'(write_data), 8'(c.data));
                memImage[c.addr] = c.data;
            end
        end
        if (read_en) begin
            checkOutput("read_has_cmd", 8'(expQ.size() != 0), 8'd1);
            checkOutput("read_while_rsp", 8'(rspPending), 8'd0);
            if (expQ.size() != 0) begin
                c = expQ.pop_front();
                checkOutput("read_op", 8'(c.op), 8'd0);
                checkOutput("read_addr", 8'(read_address), 8'(c.addr));
                rspPending = 1'b1;
                pendAddr   = c.addr;
                pendData   = read_data;
                pendErr    = expectedErr(c.addr, read_data);
            end
        end
        if (rsp_valid && rsp_ready) begin
            checkOutput("rsp_expected", 8'(rspPending), 8'd1);
            checkOutput("rsp_addr", 8'(rsp_addr), 8'(pendAddr));
            checkOutput("rsp_data", 8'(rsp_data), 8'(pendData));
            checkOutput("rsp_err", 8'(rsp_err), 8'(pendErr));
            rspPending = 1'b0;
        end
        if (cmd_valid && cmd_ready) begin
            c.op   = cmd_op;
            c.addr = cmd_addr;
            c.data = cmd_data;
            expQ.push_back(c);
        end
    endtask

    task automatic stepCycle();
        monitorCycle();
        @(posedge CLK);
        #1;
    endtask

    // Assert reset mid-cycle, check outputs at once, release and check ready
    task automatic doReset();
        RST_N = 1'b0;
        cmd_valid = 1'b0;
        write_rdy = 1'b1;
        read_rdy  = 1'b1;
        #1;
        checkOutput("rst_cmd_ready", 8'(cmd_ready), 8'd0);
        checkOutput("rst_rsp_valid", 8'(rsp_valid), 8'd0);
        checkOutput("rst_rsp_err", 8'(rsp_err), 8'd0);
        checkOutput("rst_write_en", 8'(write_en), 8'd0);
        checkOutput("rst_read_en", 8'(read_en), 8'd0);
        checkOutput("rst_write_address", 8'(write_address), 8'd0);
        checkOutput("rst_write_data", 8'(write_data), 8'd0);
        checkOutput("rst_read_address", 8'(read_address), 8'd0);
        checkOutput("rst_rsp_addr", 8'(rsp_addr), 8'd0);
        checkOutput("rst_rsp_data", 8'(rsp_data), 8'd0);
        expQ.delete();
        rspPending = 1'b0;
        memImage   = 8'd0;
        repeat (2) @(posedge CLK);
        #1;
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        checkOutput("ready_after_release", 8'(cmd_ready), 8'd1);
    endtask

    task automatic doWrite(input logic [2:0] a, input logic d);
        applyStimulus(1'b1, 1'b1, a, d, 1'b1, 1'b1, 1'b0, 1'b1);
        stepCycle();
        repeat (3) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            stepCycle();
        end
    endtask

    task automatic doRead(input string tag, input logic [2:0] a, input logic d, input logic expErr);
        applyStimulus(1'b1, 1'b0, a, 1'b0, 1'b1, 1'b1, d, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, d, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, d, 1'b0);
        checkOutput({tag, "_ren"}, 8'(read_en), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput({tag, "_rsp_valid"}, 8'(rsp_valid), 8'd1);
        checkOutput({tag, "_rsp_err"}, 8'(rsp_err), 8'(expErr));
        stepCycle();
    endtask

    initial begin
        int idx;
        logic expErrVal;

        // Power-on reset
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        doReset();

        // Write addr 5 data 1: enable exactly at N+2
        applyStimulus(1'b1, 1'b1, 3'd5, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t41_ready", 8'(cmd_ready), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t41_wen_n1", 8'(write_en), 8'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t41_wen_n2", 8'(write_en), 8'd1);
        checkOutput("t41_waddr", 8'(write_address), 8'd5);
        checkOutput("t41_wdata", 8'(write_data), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t41_wen_n3", 8'(write_en), 8'd0);
        stepCycle();

        // Read addr 5 with read_rdy low 3 cycles, response held until consumed
        applyStimulus(1'b1, 1'b0, 3'd5, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
            checkOutput("t42_ren_stall", 8'(read_en), 8'd0);
            checkOutput("t42_raddr_stall", 8'(read_address), 8'd5);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
        checkOutput("t42_ren_fire", 8'(read_en), 8'd1);
        checkOutput("t42_raddr_fire", 8'(read_address), 8'd5);
        stepCycle();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
            checkOutput("t42_rsp_valid_hold", 8'(rsp_valid), 8'd1);
            checkOutput("t42_rsp_addr_hold", 8'(rsp_addr), 8'd5);
            checkOutput("t42_rsp_data_hold", 8'(rsp_data), 8'd1);
            checkOutput("t42_ren_in_resp", 8'(read_en), 8'd0);
            stepCycle();
        end
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        checkOutput("t42_rsp_valid_take", 8'(rsp_valid), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        checkOutput("t42_rsp_valid_gone", 8'(rsp_valid), 8'd0);
        stepCycle();

        // Shadow check: mismatching then matching read of addr 2
        doWrite(3'd2, 1'b1);
        expErrVal = expectedErr(3'd2, 1'b0);
        doRead("t44_mismatch", 3'd2, 1'b0, expErrVal);
        expErrVal = expectedErr(3'd2, 1'b1);
        doRead("t44_match", 3'd2, 1'b1, expErrVal);

        // Fill the FIFO with write_rdy low, then drain and check order
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b1, 1'b1, 3'(i), 1'(i), 1'b0, 1'b0, 1'b0, 1'b0);
            checkOutput("t43_ready_fill", 8'(cmd_ready), 8'd1);
            stepCycle();
        end
        applyStimulus(1'b1, 1'b1, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t43_ready_full", 8'(cmd_ready), 8'd0);
        stepCycle();
        idx = 0;
        for (int i = 0; i < 14; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
            if (write_en) begin
                checkOutput("t43_order", 8'(write_address), 8'(idx));
                idx++;
            end
            stepCycle();
        end
        checkOutput("t43_count", 8'(idx), 8'd5);

        // Reset while in RD with read_rdy low and more commands queued
        applyStimulus(1'b1, 1'b0, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 3'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checkOutput("t45_ren_stall", 8'(read_en), 8'd0);
        checkOutput("t45_raddr", 8'(read_address), 8'd3);
        stepCycle();
        doReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
            checkOutput("t45_fifo_empty", 8'(write_en | read_en | rsp_valid), 8'd0);
            stepCycle();
        end

        // Push in the same cycle as the IDLE pop at count 1
        applyStimulus(1'b1, 1'b1, 3'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        stepCycle();
        applyStimulus(1'b1, 1'b1, 3'd6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t46_ready", 8'(cmd_ready), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t46_first_wen", 8'(write_en), 8'd1);
        checkOutput("t46_first_addr", 8'(write_address), 8'd1);
        checkOutput("t46_first_data", 8'(write_data), 8'd1);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t46_gap", 8'(write_en), 8'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t46_second_wen", 8'(write_en), 8'd1);
        checkOutput("t46_second_addr", 8'(write_address), 8'd6);
        checkOutput("t46_second_data", 8'(write_data), 8'd0);
        stepCycle();
        applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("t46_done", 8'(write_en), 8'd0);
        stepCycle();

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            stepCycle();
        end

        // Drain: everything accepted must be issued and answered
        for (int i = 0; i < 30; i++) begin
            applyStimulus(1'b0, 1'b0, 3'd0, 1'b0, 1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'b1);
            stepCycle();
        end
        checkOutput("drain_queue_empty", 8'(expQ.size()), 8'd0);
        checkOutput("drain_no_rsp_pending", 8'(rspPending), 8'd0);
        checkOutput("drain_idle_ready", 8'(cmd_ready), 8'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
